// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, board clock/baud defaults
// and the oversample divisor helper used by both the RX and TX paths.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ  = 32'd100_000_000;
  localparam int unsigned UART_BAUD_RATE = 32'd9600;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_e;

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_oversample_tick.sv
// Free-running divider producing a one-clk tick every DIV clocks; the phase
// is never realigned to the serial line.
module uart_oversample_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 32'd651
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 32'd1);

  logic [15:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  // wrap the counter at DIV-1 and flag the wrap
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = 16'd0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 16'd1;
      tick_d = 1'b0;
    end
  end

  // counter and registered tick
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= 16'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampling, mid-bit sampling.
// Optional parity stage is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = UART_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = 32'd16,
  parameter int unsigned DATA_BITS  = 32'd8,
  parameter int unsigned PARITY_ODD = 32'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BIW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] SCNT_ZERO = {SCW{1'b0}};
  localparam logic [SCW-1:0] SCNT_ONE  = SCW'(1);
  localparam logic [SCW-1:0] SCNT_MID  = SCW'(OVERSAMPLE / 32'd2 - 32'd1);
  localparam logic [SCW-1:0] SCNT_END  = SCW'(OVERSAMPLE - 32'd1);
  localparam logic [BIW-1:0] BIDX_ZERO = {BIW{1'b0}};
  localparam logic [BIW-1:0] BIDX_ONE  = BIW'(1);
  localparam logic [BIW-1:0] BIDX_LAST = BIW'(DATA_BITS - 32'd1);

  if ((OVERSAMPLE < 32'd8) || ((OVERSAMPLE % 32'd2) != 32'd0) ||
      (DATA_BITS < 32'd5) || (DATA_BITS > 32'd8) ||
      (PARITY_ODD > 32'd1) || (DIV < 32'd1)) begin : g_param_check
    $error("uart_rx: illegal parameter set");
  end

`ifdef UART_RX_PARITY_EN
  localparam logic           PAR_ODD    = (PARITY_ODD != 32'd0) ? 1'b1 : 1'b0;
  localparam uart_rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_rx_state_e AFTER_DATA = ST_STOP;
`endif

  logic sync1_q, sync2_q;
  logic rxs_s, tick_s;

  uart_rx_state_e       state_q, state_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic [BIW-1:0]       bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // two-flop synchroniser; idles high so reset must not fake a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxs_s = sync2_q;

  uart_oversample_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick_s)
  );

  // receive FSM next-state and output decode
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    bidx_d       = bidx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        scnt_d = SCNT_ZERO;
        if (tick_s && !rxs_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (scnt_q == SCNT_MID) begin
            scnt_d = SCNT_ZERO;
            // a start bit that is high again at its centre was a glitch
            if (!rxs_s) begin
              state_d = ST_DATA;
              bidx_d  = BIDX_ZERO;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (scnt_q == SCNT_END) begin
            scnt_d  = SCNT_ZERO;
            shift_d = {rxs_s, shift_q[DATA_BITS-1:1]};
            if (bidx_q == BIDX_LAST) begin
              state_d = AFTER_DATA;
            end else begin
              bidx_d = bidx_q + BIDX_ONE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end else begin
          scnt_d = scnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          if (scnt_q == SCNT_END) begin
            scnt_d  = SCNT_ZERO;
            par_d   = rxs_s;
            state_d = ST_STOP;
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end else begin
          scnt_d = scnt_q;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          if (scnt_q == SCNT_END) begin
            scnt_d = SCNT_ZERO;
            if (rxs_s) begin
              rx_data_d    = shift_q;
              rx_valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_d = (par_q != ((^shift_q) ^ PAR_ODD));
`endif
              state_d      = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end else begin
          scnt_d = scnt_q;
        end
      end
      ST_WAIT_IDLE: begin
        scnt_d = SCNT_ZERO;
        if (rxs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        scnt_d  = SCNT_ZERO;
      end
    endcase
  end

  // FSM state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      scnt_q       <= SCNT_ZERO;
      bidx_q       <= BIDX_ZERO;
      shift_q      <= {DATA_BITS{1'b0}};
      rx_data_q    <= {DATA_BITS{1'b0}};
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= (state_d != ST_IDLE);
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at a reduced clock (one bit = 160 clk).
// Honours UART_RX_PARITY_EN for the parity scenarios.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_536_000;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int EXTRA  = 1;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int EXTRA  = 0;
`endif
  localparam bit PODD_BIT = 1'b0;
  // stop bit is sampled 1.5+data(+parity) bits after the start edge
  localparam int LAT_MIN = (3 + 2 * (DB + EXTRA)) * BIT / 2;
  localparam int LAT_MAX = LAT_MIN + DIV + 6;

  logic       clk, reset, rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
    int         start_cyc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         last_perr = 1'b0;
  bit         last_ferr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // compare process: frame-level model of what each cycle must show
  initial begin
    ev_t e;
    int  lat;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        exp_data = 8'h00;
        exp_q.delete();
      end else begin
        if (rx_valid || frame_err || parity_err) begin
          check("valid_ferr_exclusive", rx_valid & frame_err, 1'b0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: valid=%0b ferr=%0b perr=%0b, expected no event",
                     rx_valid, frame_err, parity_err);
          end else begin
            e = exp_q.pop_front();
            check("event_valid", rx_valid, !e.is_ferr);
            check("event_frame_err", frame_err, e.is_ferr);
            check("event_parity_err", parity_err, e.perr);
            lat = cyc - e.start_cyc;
            tests++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
              fails++;
              $display("FAIL latency: got %0d clk, expected %0d..%0d clk", lat, LAT_MIN, LAT_MAX);
            end
            if (!e.is_ferr) exp_data = e.data;
            last_perr = parity_err;
            last_ferr = frame_err;
          end
        end
        check("rx_data_hold", rx_data, exp_data);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
    ev_t e;
    @(negedge clk);
    e.start_cyc = cyc;
    e.data      = d;
    e.is_ferr   = !stop_bit;
    e.perr      = stop_bit && PAR_EN && (par_bit != ((^d) ^ PODD_BIT));
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    fails++;
    $display("FAIL watchdog: got no end of run after 60000 clk, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v81;
    bit         seen_busy;
    v81   = 8'h81;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("init_rx_data", rx_data, 8'h00);
    check("init_rx_busy", rx_busy, 1'b0);
    repeat (BIT) @(negedge clk);

    // single frame
    send_frame(8'h55, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain("t1_drain");
    repeat (BIT / 2) @(negedge clk);
    check("t1_rx_data", rx_data, 8'h55);
    check("t1_busy_low", rx_busy, 1'b0);

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain("t2_drain");
    @(negedge clk);
    check("t2_rx_data", rx_data, 8'hFF);

    // short low glitch while idle
    @(negedge clk);
    seen_busy = 1'b0;
    rx = 1'b0;
    repeat (46) begin
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    rx = 1'b1;
    repeat (BIT - 46) begin
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    check("t3_busy_seen", seen_busy, 1'b1);
    check("t3_busy_dropped", rx_busy, 1'b0);
    check("t3_rx_data", rx_data, 8'hFF);

    // bad stop bit followed by a held-low line
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("t4_ferr_seen", exp_q.size(), 0);
    check("t4_last_ferr", last_ferr, 1'b1);
    check("t4_busy_wait_idle", rx_busy, 1'b1);
    check("t4_rx_data_kept", rx_data, 8'hFF);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check("t4_busy_released", rx_busy, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain("t4_drain");
    @(negedge clk);
    check("t4_rx_data_3c", rx_data, 8'h3C);

    // reset in the middle of the data bits
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = v81[i];
      repeat (BIT) @(negedge clk);
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rx_data_cleared", rx_data, 8'h00);
    check("t5_busy_cleared", rx_busy, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("t5_no_late_valid", rx_data, 8'h00);
    send_frame(8'h7E, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain("t5_drain");
    @(negedge clk);
    check("t5_rx_data_7e", rx_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones, so the parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain("t6_drain_bad");
    @(negedge clk);
    check("t6_perr_bad", last_perr, 1'b1);
    check("t6_rx_data_bad", rx_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    wait_drain("t6_drain_good");
    @(negedge clk);
    check("t6_perr_good", last_perr, 1'b0);
    check("t6_rx_data_good", rx_data, 8'h07);
`endif

    repeat (BIT) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the counterpart of the team's Basys3 UART TX path, at 100 MHz / 9600 baud.
- Synchronises the asynchronous serial input and derives its own 16x oversample tick from clk.
- Finds start-bit falling edges, samples each bit at mid-bit, and delivers parallel bytes with a one-cycle valid strobe.
- Sits between the board RX pin and the command/loopback logic.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate.
- OVERSAMPLE, 16: ticks per bit; must be even and at least 8.
- DATA_BITS, 8: payload bits per frame, sent LSB first; legal range 5..8.
- PARITY_ODD, 0: with parity built in, 0 selects even parity and 1 selects odd.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  last received byte; held until the next valid frame.
- rx_valid  out  1  one-cycle pulse; rx_data is new in this cycle.
- rx_busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0; both synchroniser flops=1; tick counter=0; FSM=IDLE.
- Synchroniser: two flops on rx. All decisions use the second flop (rxs). Input-to-rxs latency is 2 clk.
- Tick divisor: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; default 651.
  - 16-bit counter runs 0..DIV-1 and pulses tick for 1 clk at DIV-1.
  - The counter is free-running and is never realigned.
- Sample counter: 4 bits (log2 OVERSAMPLE); counts ticks within the current state and is cleared on every state change.
- FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP, WAIT_IDLE.
- IDLE: on a tick with rxs=0, go to START.
- START: on tick OVERSAMPLE/2-1 (mid start bit):
  - rxs=0 → DATA, bit index 0.
  - rxs=1 → IDLE. Treated as a glitch; no flags raised.
- DATA: every OVERSAMPLE ticks (mid-bit), shift rxs in LSB-first. After bit DATA_BITS-1, go to PARITY if compiled in, otherwise STOP.
- STOP: after OVERSAMPLE ticks, sample rxs.
  - rxs=1: load rx_data and pulse rx_valid next clk → IDLE.
  - rxs=0: pulse frame_err, leave rx_data unchanged, no rx_valid → WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This stops a break or stuck-low line from retriggering.
- Latency: rx_valid rises about (1.5+DATA_BITS)·bit + ≤1 tick + 3 clk after the start edge.
- rx_valid and frame_err are never high in the same cycle. There is no back-pressure: the consumer must capture within one clk, and a later frame overwrites rx_data.
- Back-to-back frames: the next start bit may begin right after the stop sample. IDLE catches it, so there is no dead time beyond one tick.
- Reset mid-frame: everything returns to reset values on the next edge, and the partial byte is discarded.
- Start-detect timing: start detection is quantised to ticks, with up to 1/16-bit phase error; mid-bit sampling tolerates it.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: adds the PARITY state after DATA, sampled at mid-bit.
  - Expected bit = XOR of the data bits, XOR PARITY_ODD.
  - On mismatch, parity_err pulses in the same cycle as rx_valid; the byte is still delivered.
  - A frame error overrides: parity_err is suppressed when frame_err fires.
- Undefined: no PARITY state, parity_err tied 0, frame length is 1+DATA_BITS+1.

Decomposition:
- Package uart_pkg:
  - rx state enum.
  - Localparam function for the DIV computation.
  - Default CLK_FREQ and BAUD_RATE constants, shared with the TX side.
- Sub-module uart_oversample_tick (counter and tick pulse, parameterised by DIV), instanced once here and reusable by TX.
- Synchroniser stays inline.

Test Plan (1 bit = 16·651 = 10416 clk):
- Send 0x55 with a valid stop bit → single rx_valid pulse, rx_data=0x55, frame_err=0, rx_busy low afterwards.
- Send 0x00 then 0xFF back-to-back, no idle gap → two rx_valid pulses ~10 bit-times apart, data 0x00 then 0xFF.
- Drive a 3000-clk low glitch on idle rx → no rx_valid and no frame_err; rx_busy drops by clk ~5500.
- Send 0xA3 with stop bit=0, then hold rx low for 3 bit-times → one frame_err pulse, no rx_valid, rx_data unchanged, FSM in WAIT_IDLE until rx goes high; a following 0x3C is received correctly.
- Assert reset for 1 clk mid-way through the data bits of 0x81 → all outputs 0, no rx_valid for that frame; the next 0x7E is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 → rx_valid with rx_data=0x07 and parity_err=1 in the same cycle; with parity bit 1 → parity_err=0.
